// File: rtl/mux_pkt_arbiter_pkg.sv
// Shared flit-type encodings, arbiter state codes and mux select constants
// for the packet-granular output-port arbiter.
package mux_pkt_arbiter_pkg;

  localparam logic [1:0] TypeNone = 2'b00;
  localparam logic [1:0] TypeHead = 2'b01;
  localparam logic [1:0] TypeData = 2'b10;
  localparam logic [1:0] TypeTail = 2'b11;

  typedef enum logic [1:0] {
    ArbIdle  = 2'b00,
    ArbLock0 = 2'b01,
    ArbLock1 = 2'b10
  } arb_state_e;

  localparam int unsigned SelPort0 = 1;
  localparam int unsigned SelPort1 = 2;

endpackage

// File: rtl/mux_pkt_arbiter_if.sv
// Flit handshake between the two input ports, the downstream sink and the arbiter.
interface mux_pkt_arbiter_if #(
  parameter int unsigned SEL_W = 5,
  parameter int unsigned TYPEW = 2
) ();

  logic             ivalid_0;
  logic [TYPEW-1:0] itype_0;
  logic             ivalid_1;
  logic [TYPEW-1:0] itype_1;
  logic             oready;
  logic [SEL_W-1:0] sel;
  logic             grant_0;
  logic             grant_1;
  logic             locked;
  logic             abort;

  modport master (
    output ivalid_0, itype_0, ivalid_1, itype_1, oready,
    input  sel, grant_0, grant_1, locked, abort
  );

  modport slave (
    input  ivalid_0, itype_0, ivalid_1, itype_1, oready,
    output sel, grant_0, grant_1, locked, abort
  );

endinterface

// File: rtl/mux_pkt_arbiter_arb_rr2.sv
// Two-input round-robin pick: a lone requester wins, a tie goes to the port
// that did not win last.
module arb_rr2 (
  input  logic [1:0] req_i,
  input  logic       rr_last_i,
  output logic       gnt_idx_o,
  output logic       any_o
);

  assign any_o     = |req_i;
  assign gnt_idx_o = (req_i == 2'b11) ? ~rr_last_i : req_i[1];

endmodule

// File: rtl/mux_pkt_arbiter.sv
// Packet-granular round-robin arbiter driving the 2:1 output mux select; holds
// the lock HEAD..TAIL, honours downstream backpressure and breaks stalled locks.
module mux_pkt_arbiter
  import mux_pkt_arbiter_pkg::*;
#(
  parameter int unsigned SEL_W     = 5,
  parameter int unsigned TYPEW     = 2,
  parameter int unsigned STALL_MAX = 64
) (
  input logic              clk,
  input logic              rst,
  mux_pkt_arbiter_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(STALL_MAX);
  localparam logic [CntW-1:0] CntLast = CntW'(STALL_MAX - 1);

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             rr_last_q, rr_last_d;
  logic [CntW-1:0]  stall_cnt_q, stall_cnt_d;

  logic [1:0] req;
  logic       gnt_idx;
  logic       req_any;
  logic       lock_valid;
  logic       lock_tail;
  logic       xfer;
  logic       grant_0;
  logic       grant_1;
  logic       abort;

  assign req[0] = bus.ivalid_0 && (bus.itype_0 == TYPEW'(TypeHead));
  assign req[1] = bus.ivalid_1 && (bus.itype_1 == TYPEW'(TypeHead));

  arb_rr2 u_arb_rr2 (
    .req_i     (req),
    .rr_last_i (rr_last_q),
    .gnt_idx_o (gnt_idx),
    .any_o     (req_any)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rr_last_d   = rr_last_q;
    stall_cnt_d = stall_cnt_q;
    lock_valid  = 1'b0;
    lock_tail   = 1'b0;
    xfer        = 1'b0;
    grant_0     = 1'b0;
    grant_1     = 1'b0;
    abort       = 1'b0;
    unique case (state_q)
      ArbIdle: begin
        stall_cnt_d = '0;
        if (req_any) begin
          state_d   = gnt_idx ? ArbLock1 : ArbLock0;
          sel_d     = gnt_idx ? SEL_W'(SelPort1) : SEL_W'(SelPort0);
          rr_last_d = gnt_idx;
        end
      end
      ArbLock0, ArbLock1: begin
        lock_valid = (state_q == ArbLock1) ? bus.ivalid_1 : bus.ivalid_0;
        lock_tail  = (state_q == ArbLock1) ? (bus.itype_1 == TYPEW'(TypeTail))
                                           : (bus.itype_0 == TYPEW'(TypeTail));
        xfer       = lock_valid && bus.oready;
        grant_0    = xfer && (state_q == ArbLock0);
        grant_1    = xfer && (state_q == ArbLock1);
        if (xfer) begin
          stall_cnt_d = '0;
          if (lock_tail) begin
            state_d = ArbIdle;
            sel_d   = '0;
          end
        end else if (!lock_valid) begin
          // Only an empty source counts; oready=0 with a valid flit is legitimate.
          if (stall_cnt_q >= CntLast) begin
            abort       = 1'b1;
            state_d     = ArbIdle;
            sel_d       = '0;
            stall_cnt_d = '0;
          end else begin
            stall_cnt_d = stall_cnt_q + CntW'(1);
          end
        end
      end
      default: begin
        state_d = ArbIdle;
        sel_d   = '0;
      end
    endcase
    // The lock is dropped at the reset edge, so nothing may be popped now.
    if (rst) begin
      grant_0 = 1'b0;
      grant_1 = 1'b0;
      abort   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ArbIdle;
      sel_q       <= '0;
      rr_last_q   <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rr_last_q   <= rr_last_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.sel     = sel_q;
  assign bus.grant_0 = grant_0;
  assign bus.grant_1 = grant_1;
  assign bus.locked  = (state_q != ArbIdle);
  assign bus.abort   = abort;

  sel_legal_a: assert property (@(posedge clk) disable iff (rst)
    !$isunknown(sel_q) &&
    ((sel_q == '0) || (sel_q == SEL_W'(SelPort0)) || (sel_q == SEL_W'(SelPort1))));

endmodule
